inst_prefetch_queue: RTL and testbench

Parametrised circular byte queue between instruction fetch and the prime decoder of the 6502 core. Fetch pushes one opcode/operand byte per cycle; decode sees the head bytes together on one bus and retires a whole instruction of 1 to PULL_MAX bytes in a single pull. A flush input empties the queue in one cycle on a taken branch or on an interrupt redirect.

---
 rtl/inst_prefetch_queue_if.sv | 43 ++++
 rtl/inst_prefetch_queue.sv | 90 +++++++++
 tb/tb_inst_prefetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Bus between instruction fetch/decode and the prefetch byte queue.
// The optional queue_err line is present only when QUEUE_ERR_EN is defined.
interface inst_prefetch_queue_if #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int PULL_MAX = 3
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int LEN_W = $clog2(PULL_MAX + 1);

   logic                         queue_flush;
   logic                         queue_push;
   logic [DATA_W-1:0]            queue_in;
   logic                         queue_pull;
   logic [LEN_W-1:0]             queue_pull_len;
   logic [PULL_MAX*DATA_W-1:0]   queue_out;
   logic [CNT_W-1:0]             queue_count;
   logic                         queue_full;
   logic                         queue_empty;
`ifdef QUEUE_ERR_EN
   logic                         queue_err;

   modport master (
      output queue_flush, queue_push, queue_in, queue_pull, queue_pull_len,
      input  queue_out, queue_count, queue_full, queue_empty, queue_err
   );

   modport slave (
      input  queue_flush, queue_push, queue_in, queue_pull, queue_pull_len,
      output queue_out, queue_count, queue_full, queue_empty, queue_err
   );
`else
   modport master (
      output queue_flush, queue_push, queue_in, queue_pull, queue_pull_len,
      input  queue_out, queue_count, queue_full, queue_empty
   );

   modport slave (
      input  queue_flush, queue_push, queue_in, queue_pull, queue_pull_len,
      output queue_out, queue_count, queue_full, queue_empty
   );
`endif
endinterface

// File: rtl/inst_prefetch_queue.sv
// Circular byte queue between 6502 instruction fetch and the decoder.
// Fetch pushes one byte per cycle; decode sees a PULL_MAX-byte head window
// and retires 1..PULL_MAX bytes per pull. Flush empties it in one cycle.
// Optional feature macro: QUEUE_ERR_EN adds a sticky queue_err flag.
module inst_prefetch_queue #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int PULL_MAX = 3
) (
   input logic                 clk,
   input logic                 queue_reset_n,
   inst_prefetch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0]          mem [DEPTH];
   logic [PTR_W-1:0]           ptr_s;
   logic [PTR_W-1:0]           ptr_e;
   logic [CNT_W-1:0]           count;
   logic [CNT_W-1:0]           len_ext;
   logic                       full;
   logic                       empty;
   logic                       len_ok;
   logic                       push_ok;
   logic                       pull_ok;
   logic [PULL_MAX*DATA_W-1:0] out_win;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign len_ext = CNT_W'(bus.queue_pull_len);
   assign len_ok  = (len_ext != '0) && (len_ext <= CNT_W'(PULL_MAX)) && (len_ext <= count);
   assign push_ok = bus.queue_push && !full && !bus.queue_flush;
   assign pull_ok = bus.queue_pull && len_ok && !bus.queue_flush;

   // Byte storage; never cleared, the count masks stale entries
   always_ff @(posedge clk) begin
      if (queue_reset_n && push_ok)
         mem[ptr_e] <= bus.queue_in;
   end

   // Pointers and occupancy; reset and flush both return to an empty queue
   always_ff @(posedge clk) begin
      if (!queue_reset_n || bus.queue_flush) begin
         ptr_s <= '0;
         ptr_e <= '0;
         count <= '0;
      end else begin
         if (push_ok)
            ptr_e <= ptr_e + 1'b1;
         if (pull_ok)
            ptr_s <= ptr_s + PTR_W'(bus.queue_pull_len);
         count <= count + CNT_W'(push_ok) - (pull_ok ? len_ext : '0);
      end
   end

   // Head window, reading across the wrap and zeroing bytes beyond count
   always_comb begin
      out_win = '0;
      for (int i = 0; i < PULL_MAX; i++) begin
         if (CNT_W'(i) < count)
            out_win[i*DATA_W +: DATA_W] = mem[ptr_s + PTR_W'(i)];
      end
   end

   assign bus.queue_out   = out_win;
   assign bus.queue_count = count;
   assign bus.queue_full  = full;
   assign bus.queue_empty = empty;

`ifdef QUEUE_ERR_EN
   logic err;
   logic err_event;

   assign err_event = !bus.queue_flush &&
                      ((bus.queue_push && full) ||
                       (bus.queue_pull && ((len_ext > count) || (len_ext > CNT_W'(PULL_MAX)))));

   // Sticky error: set on a dropped push or an over-long pull, cleared by reset or flush
   always_ff @(posedge clk) begin
      if (!queue_reset_n || bus.queue_flush)
         err <= 1'b0;
      else if (err_event)
         err <= 1'b1;
   end

   assign bus.queue_err = err;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed testbench for inst_prefetch_queue (DEPTH=16, PULL_MAX=3).
// Error-flag checks are compiled in only when QUEUE_ERR_EN is defined.
module tb_inst_prefetch_queue;
   logic clk = 1'b0;
   logic queue_reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   inst_prefetch_queue_if #(.DATA_W(8), .DEPTH(16), .PULL_MAX(3)) bus ();

   inst_prefetch_queue #(.DATA_W(8), .DEPTH(16), .PULL_MAX(3)) dut (
      .clk           (clk),
      .queue_reset_n (queue_reset_n),
      .bus           (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 ns later
   task automatic applyStimulus(input logic push, input logic [7:0] din,
                                input logic pull, input logic [1:0] len,
                                input logic flush);
      bus.queue_push     = push;
      bus.queue_in       = din;
      bus.queue_pull     = pull;
      bus.queue_pull_len = len;
      bus.queue_flush    = flush;
      @(posedge clk);
      #1;
      bus.queue_push     = 1'b0;
      bus.queue_in       = 8'h00;
      bus.queue_pull     = 1'b0;
      bus.queue_pull_len = 2'd0;
      bus.queue_flush    = 1'b0;
   endtask

   task automatic checkErr(input string tag, input logic exp);
`ifdef QUEUE_ERR_EN
      checkOutput(tag, 32'(bus.queue_err), 32'(exp));
`endif
   endtask

   // Compare all the queue status outputs together against an expected state
   task automatic checkState(input string tag, input int cnt, input logic [23:0] win);
      checkOutput({tag, "_count"}, 32'(bus.queue_count), 32'(cnt));
      checkOutput({tag, "_out"},   32'(bus.queue_out),   32'(win));
      checkOutput({tag, "_empty"}, 32'(bus.queue_empty), 32'(cnt == 0));
      checkOutput({tag, "_full"},  32'(bus.queue_full),  32'(cnt == 16));
   endtask

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence
   initial begin
      bus.queue_push     = 1'b0;
      bus.queue_in       = 8'h00;
      bus.queue_pull     = 1'b0;
      bus.queue_pull_len = 2'd0;
      bus.queue_flush    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkState("reset", 0, 24'h000000);
      checkErr("reset_err", 1'b0);
      queue_reset_n = 1'b1;

      applyStimulus(1'b1, 8'hA9, 1'b0, 2'd0, 1'b0);
      checkState("push1", 1, 24'h0000A9);
      applyStimulus(1'b1, 8'h05, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 8'h8D, 1'b0, 2'd0, 1'b0);
      checkState("push3", 3, 24'h8D05A9);

      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
      checkState("flush1", 0, 24'h000000);

      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 8'(i), 1'b0, 2'd0, 1'b0);
      checkState("fill16", 16, 24'h020100);
      checkErr("fill16_err", 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0, 2'd0, 1'b0);
      checkState("push_full", 16, 24'h020100);
      checkErr("push_full_err", 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
      checkState("drain15", 1, 24'h00000F);

      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
      checkState("flush2", 0, 24'h000000);
      checkErr("flush2_err", 1'b0);

      for (int i = 0; i < 15; i++)
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
      checkState("head15", 0, 24'h000000);
      applyStimulus(1'b1, 8'h4C, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0, 2'd0, 1'b0);
      checkState("wrap_win", 3, 24'h80004C);
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
      checkState("wrap_pull", 0, 24'h000000);
      applyStimulus(1'b1, 8'h33, 1'b0, 2'd0, 1'b0);
      checkState("after_wrap", 1, 24'h000033);

      applyStimulus(1'b1, 8'h44, 1'b0, 2'd0, 1'b0);
      checkErr("cnt2_err", 1'b0);
      applyStimulus(1'b1, 8'h11, 1'b1, 2'd3, 1'b0);
      checkState("bad_pull", 3, 24'h114433);
      checkErr("bad_pull_err", 1'b1);

      applyStimulus(1'b1, 8'h55, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 8'h66, 1'b0, 2'd0, 1'b0);
      checkOutput("cnt5", 32'(bus.queue_count), 32'd5);
      applyStimulus(1'b1, 8'h99, 1'b1, 2'd1, 1'b1);
      checkState("flush_all", 0, 24'h000000);
      checkErr("flush_all_err", 1'b0);

      applyStimulus(1'b1, 8'h77, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
      checkState("len0", 1, 24'h000077);
      checkErr("len0_err", 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b1, 2'd1, 1'b0);
      checkState("push_pull", 1, 24'h000022);

      queue_reset_n = 1'b0;
      applyStimulus(1'b1, 8'hEE, 1'b0, 2'd0, 1'b0);
      checkState("reset_mid", 0, 24'h000000);
      checkErr("reset_mid_err", 1'b0);
      queue_reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
